morse_keyer: RTL and testbench

//  Parametrised Morse encoder. Accepts character codes over a valid/ready port into a FIFO and keys
//  ITU timing onto key_out from one clock; unit length comes from UNIT_CYCLES, no divided clock.

---
 rtl/morse_pkg.sv | 33 +++
 rtl/morse_rom.sv | 52 +++++
 rtl/morse_keyer.sv | 215 +++++++++++++++++++++
 tb/tb_morse_keyer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: character codes, FSM state encodings and ROM entry type.
package morse_pkg;

   localparam logic [5:0] CODE_SPACE = 6'd36;
   localparam logic [5:0] CODE_MAX   = 6'd36;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOAD     = 3'd1;
   localparam state_t ST_MARK     = 3'd2;
   localparam state_t ST_GAP      = 3'd3;
   localparam state_t ST_CHAR_GAP = 3'd4;
   localparam state_t ST_WORD_GAP = 3'd5;

   // pattern[len-1] is keyed first; a 1 bit is a dash
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pattern;
   } rom_entry_t;

   function automatic rom_entry_t make_entry(input logic [2:0] len, input logic [4:0] pattern);
      rom_entry_t e;
      e.len     = len;
      e.pattern = pattern;
      return e;
   endfunction

   function automatic logic code_valid(input logic [5:0] code);
      return code <= CODE_MAX;
   endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code to Morse element table (A-Z, 0-9); anything else returns len=0.
import morse_pkg::*;

module morse_rom (
   input  logic [5:0] code,
   output rom_entry_t entry
);

   always_comb begin
      entry = make_entry(3'd0, 5'b00000);
      case (code)
         6'd0:  entry = make_entry(3'd2, 5'b00001); // A .-
         6'd1:  entry = make_entry(3'd4, 5'b01000);
         6'd2:  entry = make_entry(3'd4, 5'b01010);
         6'd3:  entry = make_entry(3'd3, 5'b00100);
         6'd4:  entry = make_entry(3'd1, 5'b00000);
         6'd5:  entry = make_entry(3'd4, 5'b00010);
         6'd6:  entry = make_entry(3'd3, 5'b00110);
         6'd7:  entry = make_entry(3'd4, 5'b00000);
         6'd8:  entry = make_entry(3'd2, 5'b00000);
         6'd9:  entry = make_entry(3'd4, 5'b00111);
         6'd10: entry = make_entry(3'd3, 5'b00101);
         6'd11: entry = make_entry(3'd4, 5'b00100);
         6'd12: entry = make_entry(3'd2, 5'b00011);
         6'd13: entry = make_entry(3'd2, 5'b00010);
         6'd14: entry = make_entry(3'd3, 5'b00111);
         6'd15: entry = make_entry(3'd4, 5'b00110);
         6'd16: entry = make_entry(3'd4, 5'b01101);
         6'd17: entry = make_entry(3'd3, 5'b00010);
         6'd18: entry = make_entry(3'd3, 5'b00000);
         6'd19: entry = make_entry(3'd1, 5'b00001);
         6'd20: entry = make_entry(3'd3, 5'b00001);
         6'd21: entry = make_entry(3'd4, 5'b00001);
         6'd22: entry = make_entry(3'd3, 5'b00011);
         6'd23: entry = make_entry(3'd4, 5'b01001);
         6'd24: entry = make_entry(3'd4, 5'b01011);
         6'd25: entry = make_entry(3'd4, 5'b01100);
         6'd26: entry = make_entry(3'd5, 5'b11111); // 0 -----
         6'd27: entry = make_entry(3'd5, 5'b01111);
         6'd28: entry = make_entry(3'd5, 5'b00111);
         6'd29: entry = make_entry(3'd5, 5'b00011);
         6'd30: entry = make_entry(3'd5, 5'b00001);
         6'd31: entry = make_entry(3'd5, 5'b00000);
         6'd32: entry = make_entry(3'd5, 5'b10000);
         6'd33: entry = make_entry(3'd5, 5'b11000);
         6'd34: entry = make_entry(3'd5, 5'b11100);
         6'd35: entry = make_entry(3'd5, 5'b11110);
         default: entry = make_entry(3'd0, 5'b00000);
      endcase
   end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: character FIFO plus ITU-timed keying FSM running directly off clk.
// Optional sidetone output is built when MORSE_SIDETONE_EN is defined.
import morse_pkg::*;

module morse_keyer #(
   parameter int UNIT_CYCLES = 12_000_000,
   parameter int FIFO_DEPTH  = 8,
   parameter int TONE_HALF   = 25_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       char_valid,
   input  logic [5:0] char_data,
   output logic       char_ready,
   input  logic       en,
   input  logic       abort,
   input  logic       err_clr,
   output logic       key_out,
   output logic       tone,
   output logic       fifo_full,
   output logic       green,
   output logic       red
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CYC_W = $clog2(UNIT_CYCLES);

   logic [5:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_empty;
   logic             accept;
   logic             push;
   logic             bad_code;
   logic             pop;

   state_t           state;
   state_t           state_nx;
   logic [5:0]       cur_code;
   rom_entry_t       entry;
   logic [4:0]       pattern;
   logic [2:0]       elem_idx;
   logic [2:0]       elem_nx;
   logic [CYC_W-1:0] cyc_cnt;
   logic [2:0]       unit_cnt;
   logic [2:0]       unit_target;
   logic             timed;
   logic             unit_end;
   logic             timed_done;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign char_ready = !fifo_full && !abort;
   assign accept     = char_valid && char_ready;
   assign push       = accept && code_valid(char_data);
   assign bad_code   = accept && !code_valid(char_data);
   assign pop        = (state == ST_IDLE) && !fifo_empty && en && !abort;
   assign green      = fifo_empty && (state == ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= char_data;
      if (pop)
         cur_code <= mem[rd_ptr];
      if (state == ST_LOAD)
         pattern <= entry.pattern;
   end

   // a new invalid code beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         red <= 1'b0;
      else if (bad_code)
         red <= 1'b1;
      else if (err_clr)
         red <= 1'b0;
   end

   morse_rom u_rom (
      .code  (cur_code),
      .entry (entry)
   );

   always_comb begin
      timed       = 1'b1;
      unit_target = 3'd1;
      case (state)
         ST_MARK:     unit_target = pattern[elem_idx] ? 3'd3 : 3'd1;
         ST_GAP:      unit_target = 3'd1;
         ST_CHAR_GAP: unit_target = 3'd3;
         ST_WORD_GAP: unit_target = 3'd4;
         default:     timed = 1'b0;
      endcase
   end

   assign unit_end   = (cyc_cnt == CYC_W'(UNIT_CYCLES - 1));
   assign timed_done = timed && unit_end && (unit_cnt == unit_target - 3'd1);

   always_comb begin
      state_nx = state;
      elem_nx  = elem_idx;
      case (state)
         ST_IDLE: begin
            if (pop)
               state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            if (cur_code == CODE_SPACE) begin
               state_nx = ST_WORD_GAP;
            end else if (entry.len != 3'd0) begin
               state_nx = ST_MARK;
               elem_nx  = entry.len - 3'd1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_MARK: begin
            if (timed_done) begin
               if (elem_idx == 3'd0) begin
                  state_nx = ST_CHAR_GAP;
               end else begin
                  state_nx = ST_GAP;
                  elem_nx  = elem_idx - 3'd1;
               end
            end
         end
         ST_GAP: begin
            if (timed_done)
               state_nx = ST_MARK;
         end
         ST_CHAR_GAP, ST_WORD_GAP: begin
            if (timed_done)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (abort)
         state_nx = ST_IDLE;
   end

   // key_out is registered from the next state so it changes on the same edge as the FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         key_out  <= 1'b0;
         elem_idx <= 3'd0;
         cyc_cnt  <= '0;
         unit_cnt <= 3'd0;
      end else begin
         state    <= state_nx;
         key_out  <= (state_nx == ST_MARK);
         elem_idx <= elem_nx;
         if ((state_nx != state) || !timed) begin
            cyc_cnt  <= '0;
            unit_cnt <= 3'd0;
         end else if (unit_end) begin
            cyc_cnt  <= '0;
            unit_cnt <= unit_cnt + 3'd1;
         end else begin
            cyc_cnt  <= cyc_cnt + CYC_W'(1);
         end
      end
   end

`ifdef MORSE_SIDETONE_EN
   localparam int TONE_W = $clog2(TONE_HALF + 1);

   logic [TONE_W-1:0] tone_cnt;
   logic              tone_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
      end else if (!key_out) begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
      end else if (tone_cnt == TONE_W'(TONE_HALF - 1)) begin
         tone_cnt <= '0;
         tone_q   <= !tone_q;
      end else begin
         tone_cnt <= tone_cnt + TONE_W'(1);
      end
   end

   assign tone = tone_q && key_out;
`else
   assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4, FIFO_DEPTH=8, TONE_HALF=2.
module tb_morse_keyer;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       char_valid;
   logic [5:0] char_data;
   logic       char_ready;
   logic       en;
   logic       abort;
   logic       err_clr;
   logic       key_out;
   logic       tone;
   logic       fifo_full;
   logic       green;
   logic       red;

   int checks = 0;
   int passes = 0;
   int exp_q[$];

   morse_keyer #(
      .UNIT_CYCLES (U),
      .FIFO_DEPTH  (8),
      .TONE_HALF   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .en         (en),
      .abort      (abort),
      .err_clr    (err_clr),
      .key_out    (key_out),
      .tone       (tone),
      .fifo_full  (fifo_full),
      .green      (green),
      .red        (red)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got == exp)
         passes++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [5:0] code);
      char_valid = 1'b1;
      char_data  = code;
      step();
      char_valid = 1'b0;
   endtask

   task automatic run_len(input logic val, input int max, output int n);
      n = 0;
      while (key_out == val && n < max) begin
         step();
         n++;
      end
   endtask

   // exp_q holds alternating run lengths, starting with a high run
   task automatic check_runs(input string tag);
      int n;
      for (int i = 0; i < exp_q.size(); i++) begin
         run_len((i % 2) == 0, 200, n);
         check($sformatf("%s_run%0d", tag, i), n, exp_q[i]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g;
      int tsum;
      int codes[8];

      rst = 1'b1; char_valid = 1'b0; char_data = '0;
      en = 1'b1; abort = 1'b0; err_clr = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_key", key_out, 0);
      check("rst_tone", tone, 0);
      check("rst_red", red, 0);
      check("rst_green", green, 1);
      check("rst_full", fifo_full, 0);
      check("rst_ready", char_ready, 1);

      // E: latency, single dot, green after the character gap
      push(6'd4);
      run_len(1'b0, 20, n);
      check("e_latency", n, 2);
      run_len(1'b1, 20, n);
      check("e_mark", n, U);
      check("e_green_fall", green, 0);
      g = 1;
      while (!green && g < 60) begin
         step();
         g++;
      end
      check("e_green_cycles", g, 3*U + 1);

      // A: dot then dash
      push(6'd0);
      run_len(1'b0, 20, n);
      check("a_latency", n, 2);
      exp_q = '{U, U, 3*U};
      check_runs("a");
      run_len(1'b0, 60, n);
      check("a_tail", n, 60);

      // S O space S
      en = 1'b0;
      push(6'd18);
      push(6'd14);
      push(6'd36);
      push(6'd18);
      check("sos_hold_green", green, 0);
      en = 1'b1;
      run_len(1'b0, 20, n);
      check("sos_latency", n, 2);
      exp_q = '{U, U, U, U, U, 3*U+2,
                3*U, U, 3*U, U, 3*U, 7*U+4,
                U, U, U, U, U};
      check_runs("sos");
      run_len(1'b0, 60, n);
      check("sos_tail", n, 60);

      // fill the FIFO with en=0, then key all 8 in order
      codes = '{4, 19, 8, 12, 4, 19, 8, 12};
      en = 1'b0;
      for (int i = 0; i < 8; i++)
         push(6'(codes[i]));
      check("fill_full", fifo_full, 1);
      check("fill_ready", char_ready, 0);
      char_valid = 1'b1;
      char_data  = 6'd5;
      step();
      char_valid = 1'b0;
      check("ninth_full", fifo_full, 1);
      en = 1'b1;
      run_len(1'b0, 20, n);
      check("fill_latency", n, 2);
      exp_q = '{};
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(U);   exp_q.push_back(3*U+2);
         exp_q.push_back(3*U); exp_q.push_back(3*U+2);
         exp_q.push_back(U);   exp_q.push_back(U);
         exp_q.push_back(U);   exp_q.push_back(3*U+2);
         exp_q.push_back(3*U); exp_q.push_back(U);
         exp_q.push_back(3*U);
         if (r == 0)
            exp_q.push_back(3*U+2);
      end
      check_runs("fill");
      run_len(1'b0, 80, n);
      check("fill_tail", n, 80);
      check("fill_green", green, 1);

      // en dropped mid-character: T completes, queued E waits
      push(6'd19);
      push(6'd4);
      run_len(1'b0, 20, n);
      en = 1'b0;
      run_len(1'b1, 20, n);
      check("en_t_mark", n, 3*U);
      run_len(1'b0, 60, n);
      check("en_hold", n, 60);
      check("en_hold_green", green, 0);
      en = 1'b1;
      run_len(1'b0, 20, n);
      check("en_resume", n, 2);
      run_len(1'b1, 20, n);
      check("en_e_mark", n, U);
      run_len(1'b0, 40, n);

      // invalid code sets red; set wins over clear
      char_valid = 1'b1;
      char_data  = 6'd40;
      #1;
      check("bad_ready", char_ready, 1);
      step();
      char_valid = 1'b0;
      check("bad_red", red, 1);
      check("bad_green", green, 1);
      run_len(1'b0, 30, n);
      check("bad_nokey", n, 30);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("clr_red", red, 0);
      char_valid = 1'b1;
      char_data  = 6'd63;
      err_clr    = 1'b1;
      step();
      char_valid = 1'b0;
      err_clr    = 1'b0;
      check("setwins_red", red, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("setwins_clr", red, 0);

      // abort in the middle of O's first dash with three characters queued
      en = 1'b0;
      push(6'd14);
      push(6'd18);
      push(6'd4);
      push(6'd19);
      en = 1'b1;
      run_len(1'b0, 20, n);
      for (int i = 0; i < 5; i++)
         step();
      check("abort_pre_key", key_out, 1);
      abort      = 1'b1;
      char_valid = 1'b1;
      char_data  = 6'd4;
      #1;
      check("abort_ready", char_ready, 0);
      step();
      abort      = 1'b0;
      char_valid = 1'b0;
      check("abort_key", key_out, 0);
      check("abort_green", green, 1);
      run_len(1'b0, 50, n);
      check("abort_quiet", n, 50);

      // sidetone over a T mark
      push(6'd19);
      run_len(1'b0, 20, n);
      tsum = 0;
      for (int i = 0; i < 3*U; i++) begin
         if (key_out)
            tsum += tone;
         step();
      end
`ifdef MORSE_SIDETONE_EN
      check("tone_high_cycles", tsum, 6);
`else
      check("tone_high_cycles", tsum, 0);
`endif
      check("tone_after_key", key_out, 0);
      check("tone_low", tone, 0);
      run_len(1'b0, 40, n);

      // asynchronous reset during a mark
      push(6'd4);
      run_len(1'b0, 20, n);
      check("rstmid_pre_key", key_out, 1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_key", key_out, 0);
      check("rstmid_green", green, 1);
      @(negedge clk);
      rst = 1'b0;
      run_len(1'b0, 30, n);
      check("rstmid_quiet", n, 30);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
